serial_receiver: RTL

- Downstream companion of the team's 8-bit serial transmitter. Samples the idle-high serial line and recovers start(0) + 8 data bits (LSB first) + stop(1) frames.
- Presents each received byte on a parallel output with a one-cycle valid strobe.
- Sits between the serial link and the byte-consumer logic. Flags a bad stop bit as a framing error instead of delivering the byte.

---
 rtl/serial_receiver.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/serial_receiver.sv
// serial_receiver: recovers start + 8 data (LSB first) + stop frames
// from an idle-high serial line and presents each byte with a strobe.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   serial_in  asynchronous serial line, idles high
//   data_out   last correctly framed byte, held until the next one
//   valid      one-cycle pulse, data_out has just been updated
//   busy       high whenever the receiver is not idle
//   frame_err  one-cycle pulse, stop bit was sampled low

module serial_receiver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 busy,
  output logic                 frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_M1 =
    CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT =
    3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 meta_q;
  logic                 rx_s_q;

  // Two-flop synchronizer; both stages reset to the idle level so a
  // reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      meta_q <= serial_in;
      rx_s_q <= meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      // Half a bit in: confirm the start bit, which also aligns
      // all later samples to bit centres.
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // A held-low line (break) must not decode as repeated frames.
      WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule
